// File: rtl/apb3_completer_mem.sv
// APB3 completer in front of a word-organised scratch RAM.
// Single transfers, registered pready/prdata, and a configurable number of access-phase wait states.
`timescale 1ns/1ps

module apb3_completer_mem #(
    parameter int AddressWidth  = 20,
    parameter int DataWidth     = 32,
    parameter int MemDepthWords = 1024,
    parameter int WaitStates    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [AddressWidth-1:0] paddr,
    input  logic                    pwrite,
    input  logic                    psel,
    input  logic                    penable,
    input  logic [DataWidth-1:0]    pwdata,
    output logic [DataWidth-1:0]    prdata,
    output logic                    pready
);

    localparam int OffW = $clog2(DataWidth / 8);
    localparam int IdxW = $clog2(MemDepthWords);
    localparam logic [3:0] CntInit = (WaitStates > 0) ? 4'(WaitStates - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } state_t;

    state_t                 state;
    logic [3:0]             cnt;
    logic [IdxW-1:0]        idx_q;
    logic                   wr_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [IdxW-1:0]        addr_idx;
    logic                   setup;
    logic                   access;
    logic                   mem_we;
    logic [AddressWidth-1:0] paddr_unused;

    // Byte-offset and upper address bits are ignored; the RAM aliases over the address space.
    assign addr_idx     = paddr[OffW +: IdxW];
    assign paddr_unused = paddr;
    assign setup        = psel & ~penable;
    assign access       = psel & penable;
    assign mem_we       = (state == ST_READY) & access & pready & wr_q;

    // NOTE: the RAM array has no reset; it is zero only from its declaration initialiser.
    logic [DataWidth-1:0] mem [MemDepthWords] = '{default: '0};

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pready  <= 1'b0;
            prdata  <= '0;
            cnt     <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pready <= 1'b0;
                    if (setup) begin
                        idx_q   <= addr_idx;
                        wr_q    <= pwrite;
                        wdata_q <= pwdata;
                        if (WaitStates == 0) begin
                            state  <= ST_READY;
                            pready <= 1'b1;
                            if (!pwrite) begin
                                prdata <= mem[addr_idx];
                            end
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CntInit;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!psel) begin
                        state <= ST_IDLE;
                    end else if (penable) begin
                        if (cnt == 4'd0) begin
                            state  <= ST_READY;
                            pready <= 1'b1;
                            if (!wr_q) begin
                                prdata <= mem[idx_q];
                            end
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
                ST_READY: begin
                    // Either completion or an abort (psel dropped) returns to IDLE.
                    if (!psel || (penable && pready)) begin
                        state  <= ST_IDLE;
                        pready <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    pready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb3_completer_mem.sv
// Directed bench for apb3_completer_mem: one instance with no wait states, one with three.
// Both share the bus signals except psel, so only the selected instance takes part in a transfer.
`timescale 1ns/1ps

module tb_apb3_completer_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] paddr = '0;
    logic        pwrite = 1'b0;
    logic        penable = 1'b0;
    logic        psel0 = 1'b0;
    logic        psel3 = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    apb3_completer_mem #(.AddressWidth(20), .DataWidth(32), .MemDepthWords(1024), .WaitStates(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .pwrite(pwrite), .psel(psel0),
        .penable(penable), .pwdata(pwdata), .prdata(prdata0), .pready(pready0)
    );

    apb3_completer_mem #(.AddressWidth(20), .DataWidth(32), .MemDepthWords(1024), .WaitStates(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .pwrite(pwrite), .psel(psel3),
        .penable(penable), .pwdata(pwdata), .prdata(prdata3), .pready(pready3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Call just after a rising edge; returns just after the completing rising edge.
    task automatic xfer(input bit on3, input bit wr, input logic [19:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int waits);
        bit done;
        done  = 1'b0;
        rd    = '0;
        waits = 0;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wd;
        penable = 1'b0;
        psel0   = !on3;
        psel3   = on3;
        @(negedge clk);
        check("setup_pready_low", on3 ? pready3 : pready0, 32'd0);
        @(posedge clk); #1;
        penable = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if ((on3 ? pready3 : pready0) === 1'b1) begin
                done = 1'b1;
                rd   = on3 ? prdata3 : prdata0;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        check("xfer_completed", 32'(done), 32'd1);
        psel0   = 1'b0;
        psel3   = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int          waits;

        // Reset held for 3 cycles
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pready0", 32'(pready0), 32'd0);
        check("rst_prdata0", prdata0, 32'd0);
        check("rst_pready3", 32'(pready3), 32'd0);
        check("rst_prdata3", prdata3, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_no_pready0", 32'(pready0), 32'd0);
            check("post_rst_no_pready3", 32'(pready3), 32'd0);
        end
        @(posedge clk); #1;

        // Basic write/read, zero wait states
        xfer(1'b0, 1'b1, 20'h00010, 32'hDEADBEEF, rd, waits);
        check("wr10_waits", 32'(waits), 32'd0);
        xfer(1'b0, 1'b0, 20'h00010, 32'h0, rd, waits);
        check("rd10_waits", 32'(waits), 32'd0);
        check("rd10_data", rd, 32'hDEADBEEF);

        // prdata holds across a write and idle cycles
        xfer(1'b0, 1'b1, 20'h00014, 32'h0BADC0DE, rd, waits);
        @(negedge clk);
        check("prdata_hold", prdata0, 32'hDEADBEEF);
        @(posedge clk); #1;
        xfer(1'b0, 1'b0, 20'h00014, 32'h0, rd, waits);
        check("rd14_data", rd, 32'h0BADC0DE);

        // Aliasing modulo 4 KiB, and an unaligned read
        xfer(1'b0, 1'b1, 20'h01004, 32'h12345678, rd, waits);
        xfer(1'b0, 1'b0, 20'h00004, 32'h0, rd, waits);
        check("alias_rd04", rd, 32'h12345678);
        xfer(1'b0, 1'b0, 20'h00006, 32'h0, rd, waits);
        check("alias_rd06", rd, 32'h12345678);

        // Top word and its alias at the top of the address space
        xfer(1'b0, 1'b1, 20'h00FFC, 32'hCAFEF00D, rd, waits);
        xfer(1'b0, 1'b0, 20'hFFFFC, 32'h0, rd, waits);
        check("top_word_alias", rd, 32'hCAFEF00D);

        // Back-to-back write then read of the same word
        xfer(1'b0, 1'b1, 20'h00020, 32'hA5A5A5A5, rd, waits);
        xfer(1'b0, 1'b0, 20'h00020, 32'h0, rd, waits);
        check("b2b_waits", 32'(waits), 32'd0);
        check("b2b_data", rd, 32'hA5A5A5A5);

        // Access phase without setup is ignored, and nothing is written
        paddr   = 20'h00020;
        pwrite  = 1'b1;
        pwdata  = 32'hFFFFFFFF;
        psel0   = 1'b1;
        penable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_setup_pready", 32'(pready0), 32'd0);
            @(posedge clk); #1;
        end
        psel0   = 1'b0;
        penable = 1'b0;
        xfer(1'b0, 1'b0, 20'h00020, 32'h0, rd, waits);
        check("no_setup_no_write", rd, 32'hA5A5A5A5);

        // Three wait states: read of untouched word
        xfer(1'b1, 1'b0, 20'h00000, 32'h0, rd, waits);
        check("ws3_rd0_waits", 32'(waits), 32'd3);
        check("ws3_rd0_data", rd, 32'h00000000);
        xfer(1'b1, 1'b1, 20'h00044, 32'h5A5A0001, rd, waits);
        check("ws3_wr44_waits", 32'(waits), 32'd3);

        // Abort a write by dropping psel during WAIT
        paddr   = 20'h00040;
        pwrite  = 1'b1;
        pwdata  = 32'h11111111;
        psel3   = 1'b1;
        penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel3   = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        check("abort_pready", 32'(pready3), 32'd0);
        @(posedge clk); #1;
        xfer(1'b1, 1'b0, 20'h00040, 32'h0, rd, waits);
        check("abort_no_write", rd, 32'h00000000);
        xfer(1'b1, 1'b0, 20'h00044, 32'h0, rd, waits);
        check("ws3_rd44_data", rd, 32'h5A5A0001);

        // Reset asserted during WAIT of a write
        paddr   = 20'h00040;
        pwrite  = 1'b1;
        pwdata  = 32'h22222222;
        psel3   = 1'b1;
        penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst_n   = 1'b0;
        psel3   = 1'b0;
        penable = 1'b0;
        #1;
        check("midrst_pready3", 32'(pready3), 32'd0);
        check("midrst_prdata3", prdata3, 32'd0);
        check("midrst_prdata0", prdata0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1'b1, 1'b0, 20'h00040, 32'h0, rd, waits);
        check("rst_abort_no_write", rd, 32'h00000000);
        xfer(1'b1, 1'b0, 20'h00044, 32'h0, rd, waits);
        check("ram_survives_reset", rd, 32'h5A5A0001);
        xfer(1'b0, 1'b0, 20'h00010, 32'h0, rd, waits);
        check("ram0_survives_reset", rd, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
